uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each completed byte on the receiver's one-cycle valid strobe and stores it in a first-word-fall-through FIFO for the host/consumer. It flags overrun when a byte arrives while full and a programmable fill level. An optional character-timeout detector, clocked by the shared baud tick, reports stale residual data.

## Interface
- `DEPTH`, 16, number of byte entries; power of two, ≥ 2
- `DATA_W`, 8, byte width; must match the receiver `data_out`
- `THRESH`, 8, fill level at or above which `level_irq` asserts; 1..DEPTH
- `TIMEOUT_TICKS`, 640, baud ticks of inactivity before `timeout` (4 chars × 10 bits × 16 ticks/bit)
- `clk`  in  1  system clock; the only clock
- `arst_n`  in  1  asynchronous, active-low reset
- `baud_tick`  in  1  16× oversample tick from the baud generator; used only with the timeout feature
- `rx_valid`  in  1  one-cycle strobe from the receiver: `rx_data` holds a complete byte
- `rx_data`  in  DATA_W  received byte
- `rd_en`  in  1  consumer pop request
- `rd_data`  out  DATA_W  head entry; valid while `empty`=0
- `empty`  out  1  FIFO holds no entries
- `full`  out  1  FIFO holds DEPTH entries
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- `level_irq`  out  1  `count` ≥ THRESH
- `overrun`  out  1  sticky: a byte was dropped because the FIFO was full
- `clr_overrun`  in  1  one-cycle clear of `overrun`
- `timeout`  out  1  character timeout (tied 0 when the feature is compiled out)

## Operation
- Storage: DEPTH × DATA_W array. Read and write pointers are $clog2(DEPTH)+1 bits; the MSB is the wrap bit. Empty when the pointers are equal. Full when the index bits are equal and the wrap bits differ. Pointers wrap naturally at 2·DEPTH.
- Write: `rx_valid` with `full`=0 stores `rx_data` at the write pointer and increments it.
- Write with `full`=1 and no accepted read in the same cycle: the byte is dropped, the write pointer is held, and `overrun` is set.
- Read: `rd_en` with `empty`=0 increments the read pointer. `rd_en` with `empty`=1 is ignored and produces no error flag.
- Simultaneous write and read:
  - Not full and not empty: both are performed and `count` is unchanged.
  - Full: the read frees an entry, the write is accepted, `count` stays DEPTH, and there is no overrun.
  - Empty: only the write is performed; `rd_en` is ignored.
- `overrun`: set has priority over `clr_overrun` in the same cycle. It is cleared only by `clr_overrun` or reset.
- `rd_data` = mem[rd_ptr index] (FWFT). Its value is don't-care while empty.
- `level_irq`, `empty`, `full`, `count` are registered or derived from registered pointers; there is no combinational path from `rx_valid` or `rd_en` to them.
- Reset mid-operation: pointers, `count`, `overrun`, and the timeout counter clear immediately. Memory contents are not reset. Bytes in flight are lost.

## Timing
- Reset values: `empty`=1, `full`=0, `count`=0, `level_irq`=0 (THRESH ≥ 1), `overrun`=0, `timeout`=0. `rd_data` is don't-care.
- Write latency: a byte strobed at edge N appears on `rd_data`, with `empty`=0 and updated `count`, after edge N.
- Read: the next entry appears on `rd_data` after the edge that samples `rd_en`.
- `overrun` rises after the edge sampling the dropped `rx_valid`.
- `rx_valid` is at most one cycle per byte. The FIFO does not merge back-to-back strobes; each strobe is a distinct byte.

## Configuration
- Macro: `UART_RX_TIMEOUT_EN`.
- Defined: a tick counter, width $clog2(TIMEOUT_TICKS+1), resets to 0 on any accepted write, any accepted read, or while `empty`=1.
  - Otherwise it increments on each `baud_tick` and saturates at TIMEOUT_TICKS.
  - `timeout`=1 while the counter equals TIMEOUT_TICKS. It clears the cycle after the next write or read, or when the FIFO empties.
- Undefined: no counter is built, `timeout` is constant 0, and `baud_tick` is unused.

## Structure
- Shared `uart_pkg`:
  - `UART_DATA_W` = 8
  - default FIFO depth constant
  - `UART_OVS` = 16 (ticks per bit)
  - `UART_FRAME_BITS` = 10, used to derive the default TIMEOUT_TICKS
- One sub-module, `uart_fifo_mem`: a simple dual-port register array with write port (we, waddr, wdata) and asynchronous read port (raddr, rdata). The same module is reusable for a future TX FIFO.
- Pointer, flag, overrun, and timeout logic stay in `uart_rx_fifo`.

## Test plan
- Reset, then write 0xB4, 0xA5, 0x3C; pop 3 times → `rd_data` sequence 0xB4, 0xA5, 0x3C; `count` 3→0; `empty` returns to 1.
- Write 16 bytes 0x00..0x0F (DEPTH=16) → `full`=1, `count`=16, `level_irq`=1 from the 8th write. A 17th write of 0xFF → `overrun`=1 and the head is still 0x00. `clr_overrun` → 0.
- With the FIFO full, assert `rx_valid`(0x55) and `rd_en` in the same cycle → no overrun, `count`=16, and the last entry read out after draining is 0x55.
- With the FIFO empty, assert `rd_en` alone → `count` stays 0 and no flag changes. Same-cycle `rx_valid`(0x77) + `rd_en` → `count`=1, `rd_data`=0x77.
- Write wrap: 40 write/pop pairs, with pointers wrapping twice → data order is preserved. `clr_overrun` coincident with a new overrun → `overrun` stays 1.
- `UART_RX_TIMEOUT_EN`, TIMEOUT_TICKS=640: write 1 byte, then idle → `timeout`=1 after the 640th `baud_tick`. A pop clears it, and it stays 0 while empty. Assert reset during the count → counter and `timeout` clear.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: data width, default FIFO depth, oversampling and frame size.
package uart_pkg;

   localparam int unsigned UART_DATA_W        = 8;
   localparam int unsigned UART_FIFO_DEPTH    = 16;
   localparam int unsigned UART_OVS           = 16;
   localparam int unsigned UART_FRAME_BITS    = 10;
   localparam int unsigned UART_TIMEOUT_CHARS = 4;

   // Idle time of four character frames, expressed in oversample ticks
   localparam int unsigned UART_TIMEOUT_TICKS = UART_TIMEOUT_CHARS * UART_FRAME_BITS * UART_OVS;

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// Simple dual-port register array: synchronous write port, asynchronous read port.
// Contents are intentionally not reset.
module uart_fifo_mem #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned DATA_W = 8
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DATA_W-1:0]        rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Asynchronous read port
   assign rdata = mem[raddr];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: first-word-fall-through byte buffer with overrun and fill-level flags.
// Optional character timeout enabled by defining UART_RX_TIMEOUT_EN.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH         = UART_FIFO_DEPTH,
   parameter int unsigned DATA_W        = UART_DATA_W,
   parameter int unsigned THRESH        = 8,
   parameter int unsigned TIMEOUT_TICKS = UART_TIMEOUT_TICKS
) (
   input  logic                   clk,
   input  logic                   arst_n,
   input  logic                   baud_tick,
   input  logic                   rx_valid,
   input  logic [DATA_W-1:0]      rx_data,
   input  logic                   rd_en,
   output logic [DATA_W-1:0]      rd_data,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count,
   output logic                   level_irq,
   output logic                   overrun,
   input  logic                   clr_overrun,
   output logic                   timeout
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW-1:0] wr_nxt, rd_nxt, count_nxt;
   logic          wr_ok, rd_ok, drop;
   logic          empty_nxt, full_nxt;

   // Accept/drop decisions; a read on a full FIFO frees the slot for a same-cycle write
   always_comb begin
      rd_ok     = rd_en && !empty;
      wr_ok     = rx_valid && (!full || rd_ok);
      drop      = rx_valid && full && !rd_ok;
      wr_nxt    = wr_ptr + PW'(wr_ok);
      rd_nxt    = rd_ptr + PW'(rd_ok);
      count_nxt = wr_nxt - rd_nxt;
      empty_nxt = (wr_nxt == rd_nxt);
      full_nxt  = (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]) && (wr_nxt[AW] != rd_nxt[AW]);
   end

   // Pointers and registered status flags
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         empty     <= 1'b1;
         full      <= 1'b0;
         level_irq <= 1'b0;
      end else begin
         wr_ptr    <= wr_nxt;
         rd_ptr    <= rd_nxt;
         count     <= count_nxt;
         empty     <= empty_nxt;
         full      <= full_nxt;
         level_irq <= (count_nxt >= PW'(THRESH));
      end
   end

   // Sticky overrun; a new drop wins over a same-cycle clear
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         overrun <= 1'b0;
      end else if (drop) begin
         overrun <= 1'b1;
      end else if (clr_overrun) begin
         overrun <= 1'b0;
      end
   end

   uart_fifo_mem #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_mem (
      .clk   (clk),
      .we    (wr_ok),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (rx_data),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (rd_data)
   );

`ifdef UART_RX_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);

   logic [TW-1:0] tick_cnt, tick_nxt;

   // Idle tick counter: restarts on any FIFO activity or while empty, saturates at the limit
   always_comb begin
      tick_nxt = tick_cnt;
      if (wr_ok || rd_ok || empty) begin
         tick_nxt = '0;
      end else if (baud_tick && (tick_cnt != TW'(TIMEOUT_TICKS))) begin
         tick_nxt = tick_cnt + TW'(1);
      end
   end

   // Counter register and timeout flag
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         tick_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         tick_cnt <= tick_nxt;
         timeout  <= (tick_nxt == TW'(TIMEOUT_TICKS));
      end
   end
`else
   logic unused_baud;
   assign unused_baud = baud_tick;
   assign timeout     = 1'b0;
`endif

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16, THRESH=8, TIMEOUT_TICKS=640).
module tb_uart_rx_fifo;

   logic       clk = 1'b0;
   logic       arst_n;
   logic       baud_tick;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       empty;
   logic       full;
   logic [4:0] count;
   logic       level_irq;
   logic       overrun;
   logic       clr_overrun;
   logic       timeout;

   int checks = 0;
   int errors = 0;

   uart_rx_fifo dut (
      .clk         (clk),
      .arst_n      (arst_n),
      .baud_tick   (baud_tick),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
      .empty       (empty),
      .full        (full),
      .count       (count),
      .level_irq   (level_irq),
      .overrun     (overrun),
      .clr_overrun (clr_overrun),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock, then settle 1 time unit past the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      rx_valid = 1'b1;
      rx_data  = d;
      step();
      rx_valid = 1'b0;
   endtask

   task automatic pop();
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
   endtask

   task automatic ticks(input int n);
      baud_tick = 1'b1;
      repeat (n) step();
      baud_tick = 1'b0;
   endtask

   initial begin
      arst_n      = 1'b0;
      baud_tick   = 1'b0;
      rx_valid    = 1'b0;
      rx_data     = 8'h00;
      rd_en       = 1'b0;
      clr_overrun = 1'b0;
      repeat (3) step();

      // Reset state
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_level", 32'(level_irq), 0);
      chk("rst_overrun", 32'(overrun), 0);
      chk("rst_timeout", 32'(timeout), 0);
      arst_n = 1'b1;
      step();

      // Three bytes in, three out in order
      push(8'hB4);
      chk("t1_count1", 32'(count), 1);
      chk("t1_head1", 32'(rd_data), 32'hB4);
      push(8'hA5);
      push(8'h3C);
      chk("t1_count3", 32'(count), 3);
      chk("t1_empty0", 32'(empty), 0);
      chk("t1_rd0", 32'(rd_data), 32'hB4);
      pop();
      chk("t1_rd1", 32'(rd_data), 32'hA5);
      chk("t1_count2", 32'(count), 2);
      pop();
      chk("t1_rd2", 32'(rd_data), 32'h3C);
      chk("t1_count1b", 32'(count), 1);
      pop();
      chk("t1_count0", 32'(count), 0);
      chk("t1_empty1", 32'(empty), 1);

      // Fill to DEPTH; level_irq from the 8th write
      for (int i = 0; i < 16; i++) begin
         push(8'(i));
         chk("t2_count", 32'(count), 32'(i + 1));
         chk("t2_level", 32'(level_irq), (i + 1 >= 8) ? 32'd1 : 32'd0);
         chk("t2_full", 32'(full), (i == 15) ? 32'd1 : 32'd0);
      end
      chk("t2_head", 32'(rd_data), 32'h00);
      push(8'hFF);
      chk("t2_overrun", 32'(overrun), 1);
      chk("t2_count_hold", 32'(count), 16);
      chk("t2_head_hold", 32'(rd_data), 32'h00);
      clr_overrun = 1'b1;
      step();
      clr_overrun = 1'b0;
      chk("t2_clr", 32'(overrun), 0);

      // Full with simultaneous write and read: no overrun, 0x55 ends up last
      rx_valid = 1'b1;
      rx_data  = 8'h55;
      rd_en    = 1'b1;
      step();
      rx_valid = 1'b0;
      rd_en    = 1'b0;
      chk("t3_overrun", 32'(overrun), 0);
      chk("t3_count", 32'(count), 16);
      chk("t3_full", 32'(full), 1);
      for (int i = 1; i < 16; i++) begin
         chk("t3_drain", 32'(rd_data), 32'(i));
         pop();
      end
      chk("t3_last", 32'(rd_data), 32'h55);
      pop();
      chk("t3_empty", 32'(empty), 1);
      chk("t3_count0", 32'(count), 0);

      // Read while empty is ignored; write+read on empty keeps only the write
      pop();
      chk("t4_count", 32'(count), 0);
      chk("t4_empty", 32'(empty), 1);
      chk("t4_overrun", 32'(overrun), 0);
      chk("t4_full", 32'(full), 0);
      rx_valid = 1'b1;
      rx_data  = 8'h77;
      rd_en    = 1'b1;
      step();
      rx_valid = 1'b0;
      rd_en    = 1'b0;
      chk("t4_wr_count", 32'(count), 1);
      chk("t4_wr_data", 32'(rd_data), 32'h77);
      pop();
      chk("t4_empty2", 32'(empty), 1);

      // 40 write/pop pairs across pointer wraps
      for (int k = 0; k < 40; k++) begin
         push(8'(k * 7 + 3));
         chk("t5_data", 32'(rd_data), 32'((k * 7 + 3) & 8'hFF));
         chk("t5_count", 32'(count), 1);
         pop();
         chk("t5_empty", 32'(empty), 1);
      end

      // Overrun set coincident with clear stays set
      for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
      chk("t6_full", 32'(full), 1);
      push(8'hEE);
      chk("t6_ovr1", 32'(overrun), 1);
      rx_valid    = 1'b1;
      rx_data     = 8'hEF;
      clr_overrun = 1'b1;
      step();
      rx_valid    = 1'b0;
      clr_overrun = 1'b0;
      chk("t6_set_wins", 32'(overrun), 1);
      chk("t6_head", 32'(rd_data), 32'h80);
      clr_overrun = 1'b1;
      step();
      clr_overrun = 1'b0;
      chk("t6_clr", 32'(overrun), 0);
      push(8'hF0);
      chk("t6_ovr2", 32'(overrun), 1);

      // Asynchronous reset mid-operation clears immediately
      #2;
      arst_n = 1'b0;
      #1;
      chk("t7_count", 32'(count), 0);
      chk("t7_empty", 32'(empty), 1);
      chk("t7_full", 32'(full), 0);
      chk("t7_overrun", 32'(overrun), 0);
      chk("t7_level", 32'(level_irq), 0);
      step();
      arst_n = 1'b1;
      step();

`ifdef UART_RX_TIMEOUT_EN
      // Timeout after 640 ticks of idle with data present
      push(8'h11);
      ticks(639);
      chk("to_before", 32'(timeout), 0);
      ticks(1);
      chk("to_set", 32'(timeout), 1);
      ticks(5);
      chk("to_sat", 32'(timeout), 1);
      pop();
      chk("to_pop_clr", 32'(timeout), 0);
      ticks(700);
      chk("to_empty_idle", 32'(timeout), 0);
      // Reset during count restarts it
      push(8'h22);
      ticks(300);
      #2;
      arst_n = 1'b0;
      #1;
      chk("to_rst", 32'(timeout), 0);
      step();
      arst_n = 1'b1;
      step();
      push(8'h33);
      ticks(639);
      chk("to_rst_restart", 32'(timeout), 0);
      ticks(1);
      chk("to_rst_set", 32'(timeout), 1);
`else
      // Feature compiled out: timeout never rises
      push(8'h11);
      ticks(700);
      chk("to_off", 32'(timeout), 0);
      chk("to_off_count", 32'(count), 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_uart_rx_fifo
